// File: rtl/bcd_display_driver_if.sv
// bcd_display_driver_if: request/result bundle between a controller and the BCD display driver
interface bcd_display_driver_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic [BIN_W-1:0]    value;
    logic                load;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   on;
    modport master (output value, load, input busy, done, ovf, digits, on);
    modport slave  (input value, load, output busy, done, ovf, digits, on);
endinterface

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: iterative double-dabble binary-to-BCD with saturation and display enables (BCD_LZB_EN enables leading-zero blanking)
module bcd_display_driver #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input logic clk,
    input logic reset,
    bcd_display_driver_if.slave bus
);
    localparam int DW    = 4*DIGITS;
    localparam int ACC_W = DW + 4;
    localparam int CNT_W = BIN_W > 1 ? $clog2(BIN_W) : 1;
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam logic [DW-1:0] NINES = {DIGITS{4'h9}};
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t            state, state_next;
    logic [ACC_W-1:0]  acc, acc_adj, acc_shift;
    logic [BIN_W-1:0]  sr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_next, ovf_r, last;
    logic [DW-1:0]     digits_r, digits_new;
    logic [DIGITS-1:0] on_r, on_new;
    for (genvar d = 0; d < ACC_W/4; d++) begin : g_add3
        assign acc_adj[4*d +: 4] = acc[4*d +: 4] >= 4'd5 ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
    end
    assign acc_shift  = (acc_adj << 1) | ACC_W'(sr[BIN_W-1]);
    assign last       = state == SHIFT && cnt == CNT_W'(BIN_W-1);
    assign digits_new = ovf_next ? NINES : DW'(acc_shift);
`ifdef BCD_LZB_EN
    localparam logic [DIGITS-1:0] ON_RST = DIGITS'(1);
    for (genvar d = 0; d < DIGITS; d++) begin : g_lzb
        assign on_new[d] = (d == 0) || (|digits_new[DW-1:4*d]);
    end
`else
    localparam logic [DIGITS-1:0] ON_RST = '1;
    assign on_new = '1;
`endif
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end
    // next state: accept loads outside SHIFT, leave SHIFT after the last bit
    always_comb begin
        state_next = IDLE;
        if (state == SHIFT) state_next = last ? DONE : SHIFT;
        else if (bus.load) state_next = SHIFT;
    end
    // datapath: capture, shift-add-3, and publish results only on the final shift
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            sr       <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
            ovf_r    <= 1'b0;
            digits_r <= '0;
            on_r     <= ON_RST;
        end else if (state != SHIFT && bus.load) begin
            acc      <= '0;
            sr       <= bus.value;
            cnt      <= '0;
            ovf_next <= 64'(bus.value) > MAX_VAL;
        end else if (state == SHIFT) begin
            acc <= acc_shift;
            sr  <= sr << 1;
            cnt <= cnt + 1'b1;
            if (last) begin
                digits_r <= digits_new;
                on_r     <= on_new;
                ovf_r    <= ovf_next;
            end
        end
    end
    assign bus.busy   = state == SHIFT;
    assign bus.done   = state == DONE;
    assign bus.ovf    = ovf_r;
    assign bus.digits = digits_r;
    assign bus.on     = on_r;
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: decimal-arithmetic reference model plus directed conversions
module tb_bcd_display_driver;
    localparam int BIN_W  = 20;
    localparam int DIGITS = 6;
`ifdef BCD_LZB_EN
    localparam logic [5:0] RST_ON = 6'b000001;
    localparam bit LZB = 1'b1;
`else
    localparam logic [5:0] RST_ON = 6'b111111;
    localparam bit LZB = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass = 0;
    int   total = 0;
    bit   chk_en = 1'b0;
    bcd_display_driver_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();
    bcd_display_driver #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    function automatic logic [23:0] exp_digits(input int v);
        logic [23:0] r;
        int p;
        if (v > 999999) return 24'h999999;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction
    function automatic logic [5:0] exp_on(input int v);
        logic [5:0] r;
        int p;
        if (!LZB || v > 999999) return 6'b111111;
        r = 6'b000001;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (v / p) != 0;
            p = p * 10;
        end
        return r;
    endfunction
    int          m_left = 0;
    int          m_pend = 0;
    bit          m_done = 1'b0;
    logic [23:0] m_digits = '0;
    logic [5:0]  m_on = RST_ON;
    bit          m_ovf = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_done = 1'b0; m_digits = '0; m_on = RST_ON; m_ovf = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_digits = exp_digits(m_pend);
                m_on     = exp_on(m_pend);
                m_ovf    = m_pend > 999999;
                m_done   = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (bus.load) begin
                m_pend = int'(bus.value);
                m_left = BIN_W;
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_left > 0));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("digits", 32'(bus.digits), 32'(m_digits));
            chk("on", 32'(bus.on), 32'(m_on));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        end
    end
    task automatic wait_done(input int start_busy, output int busy_cycles);
        bit seen;
        busy_cycles = start_busy;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask
    task automatic start(input int v);
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 20'(v);
        @(negedge clk);
        bus.load  = 1'b0;
        bus.value = 20'($urandom);
    endtask
    task automatic convert(input int v);
        int bc;
        start(v);
        wait_done(bus.busy ? 1 : 0, bc);
        chk("busy_len", 32'(bc), 32'(BIN_W));
    endtask
    initial begin
        int bc;
        int dones;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_digits", 32'(bus.digits), 32'h000000);
        chk("rst_on", 32'(bus.on), 32'(RST_ON));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        convert(1234);
        chk("d1234", 32'(bus.digits), 32'h001234);
        chk("on1234", 32'(bus.on), LZB ? 32'b001111 : 32'b111111);
        convert(999999);
        chk("d999999", 32'(bus.digits), 32'h999999);
        chk("ovf999999", 32'(bus.ovf), 32'd0);
        bus.load  = 1'b1;
        bus.value = '0;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(1, bc);
        chk("b2b_len", 32'(bc), 32'(BIN_W));
        chk("d0", 32'(bus.digits), 32'h000000);
        chk("on0", 32'(bus.on), LZB ? 32'b000001 : 32'b111111);
        convert(1048575);
        chk("dsat", 32'(bus.digits), 32'h999999);
        chk("ovfsat", 32'(bus.ovf), 32'd1);
        chk("onsat", 32'(bus.on), 32'b111111);
        convert(7);
        chk("d7", 32'(bus.digits), 32'h000007);
        chk("ovf7", 32'(bus.ovf), 32'd0);
        start(500000);
        repeat (3) @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 20'd42;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("hold_digits", 32'(bus.digits), 32'h000007);
        wait_done(0, bc);
        chk("d500000", 32'(bus.digits), 32'h500000);
        @(negedge clk);
        chk("no_requeue", 32'(bus.busy), 32'd0);
        start(777);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_digits", 32'(bus.digits), 32'h000000);
        chk("abort_on", 32'(bus.on), 32'(RST_ON));
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_nodone", 32'(dones), 32'd0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
